// File: rtl/viterbi_frame_sched_if.sv
// Symbol-stream, decoder-side and decoded-output signals of the frame scheduler.
// master = scheduler, slave = requesters/decoder/sink side.
interface viterbi_frame_sched_if;
  logic [1:0] sym_valid;
  logic [1:0] sym_ready;
  logic [1:0] sym_data0;
  logic [1:0] sym_data1;
  logic [1:0] sym_last;
  logic       dec_clr;
  logic       dec_en;
  logic [1:0] dec_d_in;
  logic       dec_d_out;
  logic       dec_d_valid;
  logic       out_valid;
  logic       out_bit;
  logic       out_ch;
  logic       out_last;
  logic       busy;
  logic       err_overlen;
  logic       err_timeout;

  modport master (
    input  sym_valid, sym_data0, sym_data1, sym_last, dec_d_out, dec_d_valid,
    output sym_ready, dec_clr, dec_en, dec_d_in,
           out_valid, out_bit, out_ch, out_last, busy, err_overlen, err_timeout
  );

  modport slave (
    output sym_valid, sym_data0, sym_data1, sym_last, dec_d_out, dec_d_valid,
    input  sym_ready, dec_clr, dec_en, dec_d_in,
           out_valid, out_bit, out_ch, out_last, busy, err_overlen, err_timeout
  );
endinterface

// File: rtl/viterbi_frame_sched.sv
// Round-robin per-frame sharing of one Viterbi decoder between two symbol channels.
// Symbols and decoded bits are registered one cycle; no output backpressure.
module viterbi_frame_sched #(
  parameter int MAX_FRAME  = 256,
  parameter int CLR_CYCLES = 2,
  parameter int FLUSH_MAX  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  viterbi_frame_sched_if.master bus
);
  localparam int CW = $clog2(MAX_FRAME) + 1;
  localparam int FW = $clog2(FLUSH_MAX) + 1;
  localparam int KW = $clog2(CLR_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_grant, r_rr_ptr;
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic [KW-1:0] r_clr_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_dec_clr, r_dec_en;
  logic [1:0]    r_dec_d_in;
  logic          r_out_valid, r_out_bit, r_out_ch, r_out_last;

  logic          w_accept, w_last_in, w_in_full, w_fwd, w_grant_sel;
  logic          w_overlen, w_timeout;
  logic [1:0]    w_sym, w_sym_ready;

  assign w_accept    = (r_state == S_FEED) && bus.sym_valid[r_grant];
  assign w_sym       = r_grant ? bus.sym_data1 : bus.sym_data0;
  assign w_last_in   = bus.sym_last[r_grant];
  assign w_in_full   = (r_in_cnt == CW'(MAX_FRAME - 1));
  assign w_fwd       = ((r_state == S_FEED) || (r_state == S_FLUSH)) &&
                       bus.dec_d_valid && (r_out_cnt < r_in_cnt);
  assign w_grant_sel = (&bus.sym_valid) ? r_rr_ptr : bus.sym_valid[1];

  always_comb begin
    w_next      = r_state;
    w_overlen   = 1'b0;
    w_timeout   = 1'b0;
    w_sym_ready = 2'b00;
    case (r_state)
      S_IDLE:  if (|bus.sym_valid) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_cnt == KW'(CLR_CYCLES - 1)) w_next = S_FEED;
      S_FEED: begin
        w_sym_ready[r_grant] = 1'b1;
        // A full frame without a last marker is closed as if it were last.
        if (w_accept && (w_last_in || w_in_full)) begin
          w_next    = S_FLUSH;
          w_overlen = !w_last_in;
        end
      end
      S_FLUSH: begin
        if (r_out_cnt == r_in_cnt) begin
          w_next = S_DONE;
        end else if (r_flush_cnt == FW'(FLUSH_MAX - 1)) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_clr_cnt   <= '0;
      r_flush_cnt <= '0;
      r_dec_clr   <= 1'b1;
      r_dec_en    <= 1'b0;
      r_dec_d_in  <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_ch    <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_dec_clr   <= (w_next == S_CLEAR);
      // Flush zeros start the cycle after the last symbol reaches the decoder.
      r_dec_en    <= w_accept || (r_state == S_FLUSH);
      r_dec_d_in  <= w_accept ? w_sym : 2'b00;
      r_out_valid <= w_fwd;
      r_out_bit   <= w_fwd & bus.dec_d_out;
      r_out_ch    <= w_fwd & r_grant;
      r_out_last  <= w_fwd && (r_state == S_FLUSH) && ((r_out_cnt + CW'(1)) == r_in_cnt);
      case (r_state)
        S_IDLE: if (|bus.sym_valid) begin
          r_grant     <= w_grant_sel;
          r_in_cnt    <= '0;
          r_out_cnt   <= '0;
          r_clr_cnt   <= '0;
          r_flush_cnt <= '0;
        end
        S_CLEAR: r_clr_cnt <= r_clr_cnt + KW'(1);
        S_FEED:  if (w_accept) r_in_cnt <= r_in_cnt + CW'(1);
        S_FLUSH: r_flush_cnt <= r_flush_cnt + FW'(1);
        S_DONE:  r_rr_ptr <= ~r_grant;
        default: ;
      endcase
      if (w_fwd) r_out_cnt <= r_out_cnt + CW'(1);
    end
  end

  assign bus.sym_ready   = w_sym_ready;
  assign bus.dec_clr     = r_dec_clr;
  assign bus.dec_en      = r_dec_en;
  assign bus.dec_d_in    = r_dec_d_in;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_bit     = r_out_bit;
  assign bus.out_ch      = r_out_ch;
  assign bus.out_last    = r_out_last;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_overlen = w_overlen;
  assign bus.err_timeout = w_timeout;
endmodule

// File: tb/tb_viterbi_frame_sched.sv
// Directed-frame bench for viterbi_frame_sched with a 2-cycle-latency decoder model.
// Expected outputs and grants are queued at stimulus time and popped by a monitor.
module tb_viterbi_frame_sched;
  logic clk, rst;
  viterbi_frame_sched_if bus();

  viterbi_frame_sched #(.MAX_FRAME(8), .CLR_CYCLES(2), .FLUSH_MAX(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       v0, v1, l0, l1, acc0, acc1, dec_off;
  logic [1:0] d0, d1;
  assign bus.sym_valid = {v1, v0};
  assign bus.sym_data0 = d0;
  assign bus.sym_data1 = d1;
  assign bus.sym_last  = {l1, l0};

  // Decoder model: emits dec_d_in[1] of each enabled step two cycles later.
  logic [1:0] m_vld, m_bit;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 2'b00;
      m_bit <= 2'b00;
    end else if (bus.dec_clr) begin
      m_vld <= 2'b00;
      m_bit <= 2'b00;
    end else begin
      m_vld <= {m_vld[0], bus.dec_en & ~dec_off};
      m_bit <= {m_bit[0], bus.dec_d_in[1]};
    end
  end
  assign bus.dec_d_valid = m_vld[1];
  assign bus.dec_d_out   = m_bit[1];

  logic [2:0] src0[$], src1[$];   // {last, data}
  logic [2:0] exp_q[$];           // {ch, bit, last}
  logic [1:0] gnt_q[$];           // expected sym_ready one-hot at frame start
  int n_checks = 0, n_pass = 0;
  int n_clr = 0, n_en = 0, n_ovl = 0, n_tmo = 0, n_last = 0, n_both = 0;
  logic [1:0] prev_rdy = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  function automatic logic [12:0] outvec();
    return {bus.sym_ready, bus.dec_en, bus.dec_d_in, bus.out_valid, bus.out_bit,
            bus.out_ch, bus.out_last, bus.busy, bus.err_overlen, bus.err_timeout, bus.dec_clr};
  endfunction

  task automatic clr_counts();
    n_clr = 0; n_en = 0; n_ovl = 0; n_tmo = 0; n_last = 0; n_both = 0;
  endtask

  // One cycle of the symbol sources: retire last cycle's accepts, present heads.
  task automatic tick();
    @(negedge clk);
    if (acc0 && src0.size() > 0) src0.delete(0);
    if (acc1 && src1.size() > 0) src1.delete(0);
    v0 = (src0.size() > 0); d0 = v0 ? src0[0][1:0] : 2'b00; l0 = v0 ? src0[0][2] : 1'b0;
    v1 = (src1.size() > 0); d1 = v1 ? src1[0][1:0] : 2'b00; l1 = v1 ? src1[0][2] : 1'b0;
    #1;
    acc0 = v0 && bus.sym_ready[0];
    acc1 = v1 && bus.sym_ready[1];
  endtask

  task automatic wait_idle(input string nm, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (src0.size() == 0) && (src1.size() == 0) && !bus.busy &&
             (exp_q.size() == 0) && (gnt_q.size() == 0);
    end
    chk({nm, "_drain"}, 32'(done), 32'd1);
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [2:0] e;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_rdy = 2'b00;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got ch=%0d bit=%0d last=%0d, required no output",
                     bus.out_ch, bus.out_bit, bus.out_last);
          end else begin
            e = exp_q.pop_front();
            chk("out_ch_bit_last", 32'({bus.out_ch, bus.out_bit, bus.out_last}), 32'(e));
          end
          if (bus.out_last) n_last++;
        end
        if (bus.sym_ready != 2'b00 && prev_rdy == 2'b00) begin
          if (gnt_q.size() == 0) begin
            n_checks++;
            $display("FAIL grant_unexpected: got sym_ready=%b, required no grant", bus.sym_ready);
          end else begin
            g = gnt_q.pop_front();
            chk("grant", 32'(bus.sym_ready), 32'(g));
          end
        end
        if (bus.sym_ready == 2'b11) n_both++;
        if (bus.dec_clr) n_clr++;
        if (bus.dec_en) n_en++;
        if (bus.err_overlen) n_ovl++;
        if (bus.err_timeout) n_tmo++;
        prev_rdy = bus.sym_ready;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0; acc0 = 0; acc1 = 0; dec_off = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_outputs", 32'(outvec()), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_dec_clr_low", 32'(bus.dec_clr), 32'd0);

    // Single ch0 frame 11,10,00,01 -> bits 1,1,0,0.
    clr_counts();
    src0.push_back(3'b011); src0.push_back(3'b010); src0.push_back(3'b000); src0.push_back(3'b101);
    exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b000); exp_q.push_back(3'b001);
    gnt_q.push_back(2'b01);
    wait_idle("single", 200);
    chk("single_clr_cycles", 32'(n_clr), 32'd2);
    chk("single_last_count", 32'(n_last), 32'd1);
    chk("single_busy_after", 32'(bus.busy), 32'd0);

    // Length-1 ch1 frame: symbol 10 -> bit 1, last.
    clr_counts();
    src1.push_back(3'b110);
    exp_q.push_back(3'b111);
    gnt_q.push_back(2'b10);
    for (int i = 0; i < 50 && !acc1; i++) tick();
    tick();
    chk("len1_flush_next", 32'({bus.busy, bus.sym_ready, bus.dec_en}), 32'b1001);
    wait_idle("len1", 200);
    chk("len1_last_count", 32'(n_last), 32'd1);

    // Contention: A(ch0) 11,01,10  C(ch1) 00,10,11  B(ch0) 10,10,00  D(ch1) 01,11,01.
    clr_counts();
    src0.push_back(3'b011); src0.push_back(3'b001); src0.push_back(3'b110);
    src0.push_back(3'b010); src0.push_back(3'b010); src0.push_back(3'b100);
    src1.push_back(3'b000); src1.push_back(3'b010); src1.push_back(3'b111);
    src1.push_back(3'b001); src1.push_back(3'b011); src1.push_back(3'b101);
    exp_q.push_back(3'b010); exp_q.push_back(3'b000); exp_q.push_back(3'b011);
    exp_q.push_back(3'b100); exp_q.push_back(3'b110); exp_q.push_back(3'b111);
    exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    exp_q.push_back(3'b100); exp_q.push_back(3'b110); exp_q.push_back(3'b101);
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10); gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    wait_idle("contention", 600);
    chk("contention_both_ready", 32'(n_both), 32'd0);
    chk("contention_clr_cycles", 32'(n_clr), 32'd8);
    chk("contention_last_count", 32'(n_last), 32'd4);

    // Overlength: 10 symbols (10,01,...) no last; frame closes at the 8th.
    clr_counts();
    for (int i = 0; i < 10; i++) src0.push_back((i % 2) ? 3'b001 : 3'b010);
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 7) ? 3'b001 : ((i % 2) ? 3'b000 : 3'b010));
    gnt_q.push_back(2'b01);
    nacc = 0;
    for (int i = 0; i < 60 && nacc < 8; i++) begin
      tick();
      if (acc0) begin
        nacc++;
        chk("overlen_pulse_at_accept", 32'(bus.err_overlen), 32'(nacc == 8));
      end
    end
    tick();
    chk("overlen_ready_drop", 32'(bus.sym_ready), 32'd0);
    src0.delete();
    wait_idle("overlen", 200);
    chk("overlen_pulse_count", 32'(n_ovl), 32'd1);

    // Timeout: decoder silent; ch1 frame 11,10(last).
    clr_counts();
    dec_off = 1'b1;
    src1.push_back(3'b011); src1.push_back(3'b110);
    gnt_q.push_back(2'b10);
    wait_idle("timeout", 300);
    chk("timeout_pulse_count", 32'(n_tmo), 32'd1);
    chk("timeout_dec_en_cycles", 32'(n_en), 32'd66);
    chk("timeout_no_last", 32'(n_last), 32'd0);
    dec_off = 1'b0;

    // Reset after 2 of 5 symbols, then a clean 3-symbol frame 11,00,11.
    clr_counts();
    src0.push_back(3'b011); src0.push_back(3'b010); src0.push_back(3'b001);
    src0.push_back(3'b000); src0.push_back(3'b111);
    gnt_q.push_back(2'b01);
    nacc = 0;
    for (int i = 0; i < 50 && nacc < 2; i++) begin
      tick();
      if (acc0) nacc++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midframe_reset_outputs", 32'(outvec()), 32'h1);
    src0.delete(); src1.delete(); exp_q.delete();
    acc0 = 0; acc1 = 0; v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("post_reset_gnt_drained", 32'(gnt_q.size()), 32'd0);
    clr_counts();
    src0.push_back(3'b011); src0.push_back(3'b000); src0.push_back(3'b111);
    exp_q.push_back(3'b010); exp_q.push_back(3'b000); exp_q.push_back(3'b011);
    gnt_q.push_back(2'b01);
    wait_idle("after_reset", 200);
    chk("after_reset_clr_cycles", 32'(n_clr), 32'd2);
    chk("after_reset_last_count", 32'(n_last), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
